// File: rtl/membus_arb2_pkg.sv
// Shared membus definitions: bus field ranges, arbiter state codes and the
// observable-state type used by the arbiter's debug port.
package membus_arb2_pkg;

    localparam int MA_FIRST = 18;
    localparam int MA_LAST  = 35;
    localparam int MB_FIRST = 0;
    localparam int MB_LAST  = 35;
    localparam int MA_W     = MA_LAST - MA_FIRST + 1;
    localparam int MB_W     = MB_LAST - MB_FIRST + 1;

    typedef logic [MA_FIRST:MA_LAST] ma_t;
    typedef logic [MB_FIRST:MB_LAST] mb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } state_t;

endpackage

// File: rtl/membus_rr2.sv
// Two-way pick: on a tie, round-robin favours the side not granted last;
// fixed priority always favours A.
module membus_rr2 #(
    parameter int RR = 1
) (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic pick_a,
    output logic pick_b
);

    localparam logic ROTATE = (RR != 0);

    assign pick_a = req_a & (~req_b | ~ROTATE | last_b);
    assign pick_b = req_b & ~pick_a;

endmodule

// File: rtl/membus_arb2.sv
// Two-requester membus arbiter: grants one requester a whole memory cycle and
// steers its control/address/data to the memory side and responses back.
module membus_arb2
    import membus_arb2_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   membus_rd_rq_a,
    input  logic   membus_rd_rq_b,
    input  logic   membus_wr_rq_a,
    input  logic   membus_wr_rq_b,
    input  logic   membus_rq_cyc_a,
    input  logic   membus_rq_cyc_b,
    input  logic   membus_wr_rs_a,
    input  logic   membus_wr_rs_b,
    input  ma_t    membus_ma_a,
    input  ma_t    membus_ma_b,
    input  mb_t    membus_mb_out_a,
    input  mb_t    membus_mb_out_b,
    input  logic   membus_fmc_select_a,
    input  logic   membus_fmc_select_b,
    output logic   membus_addr_ack_a,
    output logic   membus_addr_ack_b,
    output logic   membus_rd_rs_a,
    output logic   membus_rd_rs_b,
    output mb_t    membus_mb_in_a,
    output mb_t    membus_mb_in_b,
    output logic   membus_rd_rq_s,
    output logic   membus_wr_rq_s,
    output logic   membus_rq_cyc_s,
    output logic   membus_wr_rs_s,
    output logic   membus_fmc_select_s,
    output ma_t    membus_ma_s,
    output mb_t    membus_mb_out_s,
    input  logic   membus_addr_ack_s,
    input  logic   membus_rd_rs_s,
    input  mb_t    membus_mb_in_s,
    output logic   grant_a,
    output logic   grant_b,
    output state_t state
);

    state_t state_q, state_d;
    logic   last_b, inel_a, inel_b;
    logic   elig_a, elig_b, pick_a, pick_b;
    logic   take, release_now;
    logic   g_cyc, g_rd, g_wr, g_wr_rs;

    // A requester that just finished must show rq_cyc low before it may win again.
    assign elig_a = membus_rq_cyc_a & ~inel_a;
    assign elig_b = membus_rq_cyc_b & ~inel_b;

    membus_rr2 #(.RR(RR)) u_pick (
        .req_a  (elig_a),
        .req_b  (elig_b),
        .last_b (last_b),
        .pick_a (pick_a),
        .pick_b (pick_b)
    );

    assign g_cyc   = (grant_a & membus_rq_cyc_a) | (grant_b & membus_rq_cyc_b);
    assign g_rd    = (grant_a & membus_rd_rq_a)  | (grant_b & membus_rd_rq_b);
    assign g_wr    = (grant_a & membus_wr_rq_a)  | (grant_b & membus_wr_rq_b);
    assign g_wr_rs = (grant_a & membus_wr_rs_a)  | (grant_b & membus_wr_rs_b);

    always_comb begin
        state_d     = state_q;
        take        = 1'b0;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_a | pick_b) begin
                    state_d = ADDR;
                    take    = 1'b1;
                end
            end
            ADDR: begin
                if (membus_addr_ack_s) begin
                    if (g_rd)      state_d = RD;
                    else if (g_wr) state_d = WR;
                end
            end
            RD: begin
                if (membus_rd_rs_s) begin
                    if (g_wr) begin
                        state_d = WR;
                    end else begin
                        state_d     = IDLE;
                        release_now = 1'b1;
                    end
                end
            end
            WR: begin
                if (g_wr_rs) begin
                    state_d     = IDLE;
                    release_now = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Dropping rq_cyc mid-cycle aborts, whatever response is pending.
        if (state_q != IDLE && !g_cyc) begin
            state_d     = IDLE;
            release_now = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            last_b  <= 1'b1;
            inel_a  <= 1'b0;
            inel_b  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                grant_a <= pick_a;
                grant_b <= pick_b;
                last_b  <= pick_b;
            end else if (release_now) begin
                grant_a <= 1'b0;
                grant_b <= 1'b0;
            end
            inel_a <= (inel_a | (release_now & grant_a)) & membus_rq_cyc_a;
            inel_b <= (inel_b | (release_now & grant_b)) & membus_rq_cyc_b;
        end
    end

    assign membus_rd_rq_s      = g_rd;
    assign membus_wr_rq_s      = g_wr;
    assign membus_rq_cyc_s     = g_cyc;
    assign membus_wr_rs_s      = g_wr_rs;
    assign membus_fmc_select_s = (grant_a & membus_fmc_select_a) | (grant_b & membus_fmc_select_b);
    assign membus_ma_s         = ({MA_W{grant_a}} & membus_ma_a) | ({MA_W{grant_b}} & membus_ma_b);
    assign membus_mb_out_s     = ({MB_W{grant_a}} & membus_mb_out_a) | ({MB_W{grant_b}} & membus_mb_out_b);
    assign membus_mb_in_a      = {MB_W{grant_a}} & membus_mb_in_s;
    assign membus_mb_in_b      = {MB_W{grant_b}} & membus_mb_in_s;

    // Responses only reach the owner, and only in the phase that expects them.
    assign membus_addr_ack_a = grant_a & (state_q == ADDR) & membus_addr_ack_s;
    assign membus_addr_ack_b = grant_b & (state_q == ADDR) & membus_addr_ack_s;
    assign membus_rd_rs_a    = grant_a & (state_q == RD) & membus_rd_rs_s;
    assign membus_rd_rs_b    = grant_b & (state_q == RD) & membus_rd_rs_s;

    assign state = state_q;

endmodule

// File: tb/tb_membus_arb2.sv
// Bench for membus_arb2: one round-robin and one fixed-priority instance share
// stimulus; hand vectors, corner sequences and random cycles against a model.
module tb_membus_arb2;
    import membus_arb2_pkg::*;

    typedef struct packed {
        logic rd_rq_a, rd_rq_b, wr_rq_a, wr_rq_b, rq_cyc_a, rq_cyc_b;
        logic wr_rs_a, wr_rs_b, fmc_a, fmc_b, addr_ack_s, rd_rs_s;
        logic [17:0] ma_a, ma_b;
        logic [35:0] mb_out_a, mb_out_b, mb_in_s;
    } in_t;

    typedef struct packed {
        logic grant_a, grant_b, addr_ack_a, addr_ack_b, rd_rs_a, rd_rs_b;
        logic rd_rq_s, wr_rq_s, rq_cyc_s, wr_rs_s, fmc_select_s;
        logic [17:0] ma_s;
        logic [35:0] mb_out_s, mb_in_a, mb_in_b;
    } out_t;

    typedef struct {
        logic [3:0] a;       // {rq_cyc, rd_rq, wr_rq, wr_rs}
        logic [3:0] b;
        logic       ack;
        logic       rs;
        logic [6:0] exp_ctl; // {grant_a, grant_b, addr_ack_a, addr_ack_b, rd_rs_a, rd_rs_b, wr_rs_s}
        state_t     exp_st;
    } vec_t;

    localparam int P_ADDR = 0;
    localparam int P_RD   = 1;
    localparam int P_WR   = 2;
    localparam logic [35:0] MBIN  = 36'o777740000100;
    localparam logic [35:0] WDATA = 36'o123456111222;
    localparam logic [35:0] ADATA = 36'o555000555000;

    logic   clk = 1'b0;
    logic   reset;
    in_t    in;
    out_t   o [2];
    state_t st [2];

    int errors = 0;
    int checks = 0;

    // model: owner -1 none / 0 A / 1 B, phase of the owned cycle, last winner, lockouts
    int m_owner [2];
    int m_phase [2];
    int m_last  [2];
    bit m_blk   [2][2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        membus_arb2 #(.RR(k == 0 ? 1 : 0)) dut (
            .clk                 (clk),
            .reset               (reset),
            .membus_rd_rq_a      (in.rd_rq_a),
            .membus_rd_rq_b      (in.rd_rq_b),
            .membus_wr_rq_a      (in.wr_rq_a),
            .membus_wr_rq_b      (in.wr_rq_b),
            .membus_rq_cyc_a     (in.rq_cyc_a),
            .membus_rq_cyc_b     (in.rq_cyc_b),
            .membus_wr_rs_a      (in.wr_rs_a),
            .membus_wr_rs_b      (in.wr_rs_b),
            .membus_ma_a         (in.ma_a),
            .membus_ma_b         (in.ma_b),
            .membus_mb_out_a     (in.mb_out_a),
            .membus_mb_out_b     (in.mb_out_b),
            .membus_fmc_select_a (in.fmc_a),
            .membus_fmc_select_b (in.fmc_b),
            .membus_addr_ack_a   (o[k].addr_ack_a),
            .membus_addr_ack_b   (o[k].addr_ack_b),
            .membus_rd_rs_a      (o[k].rd_rs_a),
            .membus_rd_rs_b      (o[k].rd_rs_b),
            .membus_mb_in_a      (o[k].mb_in_a),
            .membus_mb_in_b      (o[k].mb_in_b),
            .membus_rd_rq_s      (o[k].rd_rq_s),
            .membus_wr_rq_s      (o[k].wr_rq_s),
            .membus_rq_cyc_s     (o[k].rq_cyc_s),
            .membus_wr_rs_s      (o[k].wr_rs_s),
            .membus_fmc_select_s (o[k].fmc_select_s),
            .membus_ma_s         (o[k].ma_s),
            .membus_mb_out_s     (o[k].mb_out_s),
            .membus_addr_ack_s   (in.addr_ack_s),
            .membus_rd_rs_s      (in.rd_rs_s),
            .membus_mb_in_s      (in.mb_in_s),
            .grant_a             (o[k].grant_a),
            .grant_b             (o[k].grant_b),
            .state               (st[k])
        );
    end

    function automatic out_t model_out(int k);
        out_t e;
        e = '0;
        if (m_owner[k] == 0) begin
            e.grant_a      = 1'b1;
            e.rd_rq_s      = in.rd_rq_a;
            e.wr_rq_s      = in.wr_rq_a;
            e.rq_cyc_s     = in.rq_cyc_a;
            e.wr_rs_s      = in.wr_rs_a;
            e.fmc_select_s = in.fmc_a;
            e.ma_s         = in.ma_a;
            e.mb_out_s     = in.mb_out_a;
            e.mb_in_a      = in.mb_in_s;
            e.addr_ack_a   = in.addr_ack_s && m_phase[k] == P_ADDR;
            e.rd_rs_a      = in.rd_rs_s && m_phase[k] == P_RD;
        end else if (m_owner[k] == 1) begin
            e.grant_b      = 1'b1;
            e.rd_rq_s      = in.rd_rq_b;
            e.wr_rq_s      = in.wr_rq_b;
            e.rq_cyc_s     = in.rq_cyc_b;
            e.wr_rs_s      = in.wr_rs_b;
            e.fmc_select_s = in.fmc_b;
            e.ma_s         = in.ma_b;
            e.mb_out_s     = in.mb_out_b;
            e.mb_in_b      = in.mb_in_s;
            e.addr_ack_b   = in.addr_ack_s && m_phase[k] == P_ADDR;
            e.rd_rs_b      = in.rd_rs_s && m_phase[k] == P_RD;
        end
        return e;
    endfunction

    task automatic model_next(int k);
        int win, rel, w;
        bit ca, cb, ea, eb, cyc, rd, wr, wrs;
        ca  = in.rq_cyc_a;
        cb  = in.rq_cyc_b;
        rel = -1;
        if (reset) begin
            m_owner[k]  = -1;
            m_last[k]   = 1;
            m_blk[k][0] = 1'b0;
            m_blk[k][1] = 1'b0;
            return;
        end
        if (m_owner[k] < 0) begin
            ea  = ca && !m_blk[k][0];
            eb  = cb && !m_blk[k][1];
            win = -1;
            if (ea && eb)  win = (k == 0) ? 1 - m_last[k] : 0;
            else if (ea)   win = 0;
            else if (eb)   win = 1;
            if (win >= 0) begin
                m_owner[k] = win;
                m_phase[k] = P_ADDR;
                m_last[k]  = win;
            end
        end else begin
            w   = m_owner[k];
            cyc = (w == 0) ? ca : cb;
            rd  = (w == 0) ? in.rd_rq_a : in.rd_rq_b;
            wr  = (w == 0) ? in.wr_rq_a : in.wr_rq_b;
            wrs = (w == 0) ? in.wr_rs_a : in.wr_rs_b;
            if (!cyc) rel = w;
            else if (m_phase[k] == P_ADDR) begin
                if (in.addr_ack_s && rd)      m_phase[k] = P_RD;
                else if (in.addr_ack_s && wr) m_phase[k] = P_WR;
            end else if (m_phase[k] == P_RD) begin
                if (in.rd_rs_s && wr)      m_phase[k] = P_WR;
                else if (in.rd_rs_s)       rel = w;
            end else if (wrs) rel = w;
            if (rel >= 0) m_owner[k] = -1;
        end
        m_blk[k][0] = (m_blk[k][0] || rel == 0) && ca;
        m_blk[k][1] = (m_blk[k][1] || rel == 1) && cb;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(string name, out_t act, out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        chk_out("model_rr1", o[0], model_out(0));
        chk_out("model_rr0", o[1], model_out(1));
    endtask

    task automatic advance();
        model_next(0);
        model_next(1);
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic drive(logic [3:0] a, logic [3:0] b, logic ack, logic rs);
        {in.rq_cyc_a, in.rd_rq_a, in.wr_rq_a, in.wr_rs_a} = a;
        {in.rq_cyc_b, in.rd_rq_b, in.wr_rq_b, in.wr_rs_b} = b;
        in.addr_ack_s = ack;
        in.rd_rs_s    = rs;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [17];
        logic [6:0] ctl;
        logic [35:0] exp_wd;

        tbl[0]  = '{4'b1100, 4'b0000, 1'b0, 1'b0, 7'b0000000, IDLE};
        tbl[1]  = '{4'b1100, 4'b0000, 1'b0, 1'b0, 7'b1000000, ADDR};
        tbl[2]  = '{4'b1100, 4'b0000, 1'b1, 1'b0, 7'b1010000, ADDR};
        tbl[3]  = '{4'b1100, 4'b0000, 1'b0, 1'b1, 7'b1000100, RD};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 7'b0000000, IDLE};
        tbl[5]  = '{4'b0000, 4'b1010, 1'b0, 1'b0, 7'b0000000, IDLE};
        tbl[6]  = '{4'b0000, 4'b1010, 1'b0, 1'b0, 7'b0100000, ADDR};
        tbl[7]  = '{4'b0000, 4'b1010, 1'b1, 1'b0, 7'b0101000, ADDR};
        tbl[8]  = '{4'b0000, 4'b1011, 1'b0, 1'b0, 7'b0100001, WR};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 7'b0000000, IDLE};
        tbl[10] = '{4'b1110, 4'b0000, 1'b0, 1'b0, 7'b0000000, IDLE};
        tbl[11] = '{4'b1110, 4'b0000, 1'b0, 1'b0, 7'b1000000, ADDR};
        tbl[12] = '{4'b1110, 4'b0000, 1'b1, 1'b0, 7'b1010000, ADDR};
        tbl[13] = '{4'b1110, 4'b0000, 1'b0, 1'b1, 7'b1000100, RD};
        tbl[14] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 7'b1000001, WR};
        tbl[15] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 7'b0000000, IDLE};
        tbl[16] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 7'b0000000, IDLE};

        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_phase[k] = P_ADDR;
            m_last[k]  = 1;
            m_blk[k][0] = 1'b0;
            m_blk[k][1] = 1'b0;
        end

        // clock/reset
        in    = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("reset_grants", 64'({o[0].grant_a, o[0].grant_b, o[1].grant_a, o[1].grant_b}), 64'(0));
        chk("reset_state", 64'(st[0]), 64'(IDLE));
        advance();
        reset = 1'b0;

        // directed vectors: A read, B write, A read-modify-write, stray responses
        in.ma_a     = 18'o000200;
        in.ma_b     = 18'o000300;
        in.mb_out_a = ADATA;
        in.mb_out_b = WDATA;
        in.mb_in_s  = MBIN;
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].ack, tbl[i].rs);
            settle();
            ctl = {o[0].grant_a, o[0].grant_b, o[0].addr_ack_a, o[0].addr_ack_b,
                   o[0].rd_rs_a, o[0].rd_rs_b, o[0].wr_rs_s};
            chk($sformatf("vec%0d_ctl", i), 64'(ctl), 64'(tbl[i].exp_ctl));
            chk($sformatf("vec%0d_state", i), 64'(st[0]), 64'(tbl[i].exp_st));
            chk($sformatf("vec%0d_mb_in_a", i), 64'(o[0].mb_in_a),
                64'(tbl[i].exp_ctl[6] ? MBIN : 36'd0));
            exp_wd = tbl[i].exp_ctl[6] ? ADATA : (tbl[i].exp_ctl[5] ? WDATA : 36'd0);
            chk($sformatf("vec%0d_mb_out_s", i), 64'(o[0].mb_out_s), 64'(exp_wd));
            chk($sformatf("vec%0d_ma_s", i), 64'(o[0].ma_s),
                64'(tbl[i].exp_ctl[6] ? 18'o000200 : (tbl[i].exp_ctl[5] ? 18'o000300 : 18'd0)));
            advance();
        end

        // simultaneous requests across three rounds
        reset_dut();
        drive(4'b1100, 4'b1100, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b1100, 1'b1, 1'b0); settle();
        chk("tie1_first", 64'({o[0].grant_a, o[0].grant_b, o[1].grant_a, o[1].grant_b}), 64'(4'b1010));
        advance();
        drive(4'b1100, 4'b1100, 1'b0, 1'b1); step();
        drive(4'b1100, 4'b1100, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b1100, 1'b1, 1'b0); settle();
        chk("tie1_second", 64'({o[0].grant_a, o[0].grant_b, o[1].grant_a, o[1].grant_b}), 64'(4'b0101));
        advance();
        drive(4'b1100, 4'b1100, 1'b0, 1'b1); step();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b1100, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b1100, 1'b1, 1'b0); settle();
        chk("tie2_first", 64'({o[0].grant_a, o[0].grant_b, o[1].grant_a, o[1].grant_b}), 64'(4'b1010));
        advance();
        drive(4'b1100, 4'b0000, 1'b0, 1'b1); step();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b1100, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b1100, 1'b0, 1'b0); settle();
        chk("tie3_rr1", 64'({o[0].grant_a, o[0].grant_b}), 64'(2'b01));
        chk("tie3_rr0", 64'({o[1].grant_a, o[1].grant_b}), 64'(2'b10));
        advance();

        // reset while in RD, then abort from ADDR
        reset_dut();
        drive(4'b1100, 4'b0000, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b0000, 1'b1, 1'b0); step();
        reset = 1'b1;
        drive(4'b1100, 4'b0000, 1'b0, 1'b0); settle();
        chk("pre_reset_rd", 64'(st[0]), 64'(RD));
        advance();
        reset = 1'b0;
        drive(4'b1100, 4'b0000, 1'b0, 1'b1); settle();
        chk("post_reset_state", 64'(st[0]), 64'(IDLE));
        chk("post_reset_outs", 64'({o[0].grant_a, o[0].rq_cyc_s, o[0].rd_rq_s, o[0].rd_rs_a, o[0].ma_s}), 64'(0));
        advance();
        drive(4'b0100, 4'b0000, 1'b0, 1'b0); settle();
        chk("abort_in_addr", 64'(st[0]), 64'(ADDR));
        advance();
        drive(4'b0000, 4'b0000, 1'b0, 1'b1); settle();
        chk("abort_state", 64'(st[0]), 64'(IDLE));
        chk("abort_late_rs", 64'({o[0].grant_a, o[0].rd_rs_a, o[0].rq_cyc_s, o[0].ma_s}), 64'(0));
        advance();

        // A keeps rq_cyc high after completing
        reset_dut();
        drive(4'b1100, 4'b0000, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b0000, 1'b1, 1'b0); step();
        drive(4'b1100, 4'b0000, 1'b0, 1'b1); step();
        drive(4'b1100, 4'b0000, 1'b0, 1'b0); settle();
        chk("hold_no_regrant1", 64'(o[0].grant_a), 64'(0));
        advance();
        settle();
        chk("hold_no_regrant2", 64'(o[0].grant_a), 64'(0));
        advance();
        drive(4'b0000, 4'b0000, 1'b0, 1'b0); step();
        drive(4'b1100, 4'b0000, 1'b0, 1'b0); step();
        settle();
        chk("hold_regrant", 64'(o[0].grant_a), 64'(1));
        advance();

        // randomized traffic against the model
        reset_dut();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) in.rq_cyc_a = ~in.rq_cyc_a;
            if ($urandom_range(0, 7) == 0) in.rq_cyc_b = ~in.rq_cyc_b;
            in.rd_rq_a    = 1'($urandom_range(0, 1));
            in.rd_rq_b    = 1'($urandom_range(0, 1));
            in.wr_rq_a    = 1'($urandom_range(0, 1));
            in.wr_rq_b    = 1'($urandom_range(0, 1));
            in.wr_rs_a    = ($urandom_range(0, 3) == 0);
            in.wr_rs_b    = ($urandom_range(0, 3) == 0);
            in.fmc_a      = 1'($urandom_range(0, 1));
            in.fmc_b      = 1'($urandom_range(0, 1));
            in.addr_ack_s = ($urandom_range(0, 2) == 0);
            in.rd_rs_s    = ($urandom_range(0, 2) == 0);
            in.ma_a       = 18'($urandom());
            in.ma_b       = 18'($urandom());
            in.mb_out_a   = 36'({$urandom(), $urandom()});
            in.mb_out_b   = 36'({$urandom(), $urandom()});
            in.mb_in_s    = 36'({$urandom(), $urandom()});
            reset         = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/membus_arb2.md
MEMBUS_ARB2 -- requirements
Module: membus_arb2

Interface
REQ-001 Parameter RR, default 1: 1 = round-robin between requesters A and B; 0 = fixed priority, A wins.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 membus_rd_rq_a/_b, membus_wr_rq_a/_b  input  1 each  requester read/write request.
REQ-005 membus_rq_cyc_a/_b  input  1 each  requester memory-cycle request.
REQ-006 membus_wr_rs_a/_b  input  1 each  requester write-restart pulse (write data valid).
REQ-007 membus_ma_a/_b  input  [18:35] each  requester address.
REQ-008 membus_mb_out_a/_b  input  [0:35] each  requester write data.
REQ-009 membus_fmc_select_a/_b  input  1 each  requester fast-memory select.
REQ-010 membus_addr_ack_a/_b, membus_rd_rs_a/_b  output  1 each  acknowledge/read-restart routed to requester.
REQ-011 membus_mb_in_a/_b  output  [0:35] each  read data routed to requester.
REQ-012 membus_rd_rq_s, membus_wr_rq_s, membus_rq_cyc_s, membus_wr_rs_s, membus_fmc_select_s  output  1 each  memory-side control.
REQ-013 membus_ma_s  output  [18:35]; membus_mb_out_s  output  [0:35]  memory-side address/data.
REQ-014 membus_addr_ack_s, membus_rd_rs_s  input  1 each; membus_mb_in_s  input  [0:35]  memory-side responses.
REQ-015 grant_a, grant_b  output  1 each  registered grant status.

Function
REQ-016 States: IDLE, ADDR (await addr_ack), RD (await rd_rs), WR (await requester wr_rs).
REQ-017 IDLE: an eligible requester with rq_cyc=1 is granted at the next edge; state becomes ADDR; grant latency exactly 1 clock.
REQ-018 Simultaneous eligible requests: RR=1 grants the requester not granted last (last-granted resets to B, so A wins the first tie); RR=0 grants A.
REQ-019 Memory-side control, ma and fmc_select are the granted requester's inputs ANDed with its grant; all zero when no grant.
REQ-020 membus_mb_out_s = granted requester's mb_out, else 0; membus_mb_in_s goes to the granted requester's mb_in only, other mb_in = 0.
REQ-021 addr_ack_s and rd_rs_s pass combinationally to the granted requester only; the non-granted requester always sees 0.
REQ-022 ADDR + addr_ack_s: rd_rq=1 -> RD; rd_rq=0, wr_rq=1 -> WR.
REQ-023 RD + rd_rs_s: wr_rq=1 (read-modify-write) -> WR; otherwise -> IDLE, grant released.
REQ-024 WR + granted wr_rs -> IDLE, grant released; wr_rs is forwarded in the same cycle.
REQ-025 Granted requester drops rq_cyc in ADDR/RD/WR -> IDLE next edge (abort); no responses routed afterwards.
REQ-026 After release, the same requester is ineligible until its rq_cyc has been sampled 0 for at least one clock; the other requester may be granted immediately.
REQ-027 Response pulses arriving in IDLE, or not matching the current state, are dropped and do not change state.

Reset
REQ-028 reset, including mid-cycle: state IDLE, grant_a=grant_b=0, last-granted=B, both ineligibility flags cleared; all outputs 0 the following cycle.

Structure
REQ-029 The shared membus header holds the state codes and the address/data width constants ([18:35], [0:35]).
REQ-030 A single sub-module, membus_rr2, holds the 2-way pick logic (requests, last-granted, RR -> grant); the FSM, eligibility flags and steering stay in membus_arb2.

Verification
REQ-031 A read, ma_a=o000200, memory returns o777740000100 -> grant_a one clock after rq_cyc; mb_in_a=o777740000100 with rd_rs_a; mb_in_b=0; release to IDLE.
REQ-032 A and B rq_cyc in the same cycle after reset, RR=1 -> A served first, then B; repeat with RR=1 -> B first; RR=0 -> A first both times.
REQ-033 B write, ma_b=o000300, mb_out_b=o123456111222 -> addr_ack_b, then wr_rs_b forwarded as wr_rs_s with mb_out_s=o123456111222; IDLE next edge.
REQ-034 A read-modify-write -> states ADDR, RD, WR in order; grant held through wr_rs_a.
REQ-035 Reset asserted in RD, and separately A dropping rq_cyc in ADDR -> IDLE next edge; all memory-side outputs 0; a late rd_rs_s is not routed.
REQ-036 A holds rq_cyc high after completion while B idle -> A not re-granted until rq_cyc_a has been 0 for one cycle.
